// File: rtl/spu_imm_pkg.sv
// spu_imm_pkg: immediate formats, round-robin pointer encoding and field widths
package spu_imm_pkg;

    typedef enum logic [1:0] {
        IMM7  = 2'b00,
        IMM10 = 2'b01,
        IMM16 = 2'b10,
        IMM18 = 2'b11
    } imm_fmt_e;

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } rr_ptr_e;

    localparam int W_IMM7  = 7;
    localparam int W_IMM10 = 10;
    localparam int W_IMM16 = 16;
    localparam int W_IMM18 = 18;

endpackage

// File: rtl/sign_ext.sv
// sign_ext: combinational sign extension of a 7/10/16/18-bit immediate to W_OUT bits
module sign_ext
    import spu_imm_pkg::*;
#(
    parameter int W_OUT = 128
) (
    input  imm_fmt_e           sel,
    input  logic [W_IMM7-1:0]  imm7,
    input  logic [W_IMM10-1:0] imm10,
    input  logic [W_IMM16-1:0] imm16,
    input  logic [W_IMM18-1:0] imm18,
    output logic [W_OUT-1:0]   res
);

    always_comb begin
        res = sel == IMM7  ? {{(W_OUT-W_IMM7){imm7[W_IMM7-1]}}, imm7} :
              sel == IMM10 ? {{(W_OUT-W_IMM10){imm10[W_IMM10-1]}}, imm10} :
              sel == IMM16 ? {{(W_OUT-W_IMM16){imm16[W_IMM16-1]}}, imm16} :
                             {{(W_OUT-W_IMM18){imm18[W_IMM18-1]}}, imm18};
    end

endmodule

// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter: round-robin sharing of one sign extender between even and odd pipes,
// each pipe owning a registered result slot held until acknowledged.
module imm_ext_arbiter
    import spu_imm_pkg::*;
#(
    parameter int W_OUT = 128,
    parameter int W_TAG = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ev_req,
    input  logic [1:0]       ev_sel,
    input  logic [17:0]      ev_imm,
    input  logic [W_TAG-1:0] ev_tag,
    output logic             ev_gnt,
    output logic             ev_res_vld,
    output logic [W_OUT-1:0] ev_res,
    output logic [W_TAG-1:0] ev_res_tag,
    input  logic             ev_res_ack,
    input  logic             od_req,
    input  logic [1:0]       od_sel,
    input  logic [17:0]      od_imm,
    input  logic [W_TAG-1:0] od_tag,
    output logic             od_gnt,
    output logic             od_res_vld,
    output logic [W_OUT-1:0] od_res,
    output logic [W_TAG-1:0] od_res_tag,
    input  logic             od_res_ack
);

    rr_ptr_e          ptr_q, ptr_d;
    logic             ev_vld_q, ev_vld_d, od_vld_q, od_vld_d;
    logic [W_OUT-1:0] ev_res_q, ev_res_d, od_res_q, od_res_d;
    logic [W_TAG-1:0] ev_tag_q, ev_tag_d, od_tag_q, od_tag_d;
    logic             ev_elig, od_elig;
    imm_fmt_e         mux_sel;
    logic [17:0]      mux_imm;
    logic [W_OUT-1:0] ext_res;

    sign_ext #(.W_OUT(W_OUT)) u_sign_ext (
        .sel   (mux_sel),
        .imm7  (mux_imm[W_IMM7-1:0]),
        .imm10 (mux_imm[W_IMM10-1:0]),
        .imm16 (mux_imm[W_IMM16-1:0]),
        .imm18 (mux_imm[W_IMM18-1:0]),
        .res   (ext_res)
    );

    // Acks reach the grant only through the slot-free term; results come from flops.
    always_comb begin
        ev_elig  = rst_n && ev_req && (!ev_vld_q || ev_res_ack);
        od_elig  = rst_n && od_req && (!od_vld_q || od_res_ack);
        ev_gnt   = ev_elig && (!od_elig || ptr_q == ODD);
        od_gnt   = od_elig && !ev_gnt;
        mux_sel  = imm_fmt_e'(ev_gnt ? ev_sel : od_sel);
        mux_imm  = ev_gnt ? ev_imm : od_imm;
        ev_vld_d = ev_gnt || (ev_vld_q && !ev_res_ack);
        od_vld_d = od_gnt || (od_vld_q && !od_res_ack);
        ev_res_d = ev_gnt ? ext_res : ev_res_q;
        od_res_d = od_gnt ? ext_res : od_res_q;
        ev_tag_d = ev_gnt ? ev_tag : ev_tag_q;
        od_tag_d = od_gnt ? od_tag : od_tag_q;
        ptr_d    = ev_gnt ? EVEN : od_gnt ? ODD : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q    <= ODD;
            ev_vld_q <= 1'b0;
            od_vld_q <= 1'b0;
            ev_res_q <= '0;
            od_res_q <= '0;
            ev_tag_q <= '0;
            od_tag_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            ev_vld_q <= ev_vld_d;
            od_vld_q <= od_vld_d;
            ev_res_q <= ev_res_d;
            od_res_q <= od_res_d;
            ev_tag_q <= ev_tag_d;
            od_tag_q <= od_tag_d;
        end
    end

    assign ev_res_vld = ev_vld_q;
    assign od_res_vld = od_vld_q;
    assign ev_res     = ev_res_q;
    assign od_res     = od_res_q;
    assign ev_res_tag = ev_tag_q;
    assign od_res_tag = od_tag_q;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// tb_imm_ext_arbiter: directed scenarios plus randomized traffic against a behavioural model
module tb_imm_ext_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ev_req, od_req, ev_res_ack, od_res_ack;
    logic [1:0]   ev_sel, od_sel;
    logic [17:0]  ev_imm, od_imm;
    logic [6:0]   ev_tag, od_tag, ev_res_tag, od_res_tag;
    logic         ev_gnt, od_gnt, ev_res_vld, od_res_vld;
    logic [127:0] ev_res, od_res;

    int n_chk = 0;
    int n_fail = 0;

    // model state: index 0 = even, 1 = odd; m_last is the pipe granted most recently
    logic         m_vld [2];
    logic [127:0] m_res [2];
    logic [6:0]   m_tag [2];
    int           m_last;
    logic         e_gnt [2];

    always #5 clk = ~clk;

    imm_ext_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .ev_req(ev_req), .ev_sel(ev_sel), .ev_imm(ev_imm), .ev_tag(ev_tag), .ev_gnt(ev_gnt),
        .ev_res_vld(ev_res_vld), .ev_res(ev_res), .ev_res_tag(ev_res_tag), .ev_res_ack(ev_res_ack),
        .od_req(od_req), .od_sel(od_sel), .od_imm(od_imm), .od_tag(od_tag), .od_gnt(od_gnt),
        .od_res_vld(od_res_vld), .od_res(od_res), .od_res_tag(od_res_tag), .od_res_ack(od_res_ack)
    );

    function automatic logic [127:0] ref_ext(input logic [1:0] sel, input logic [17:0] imm);
        int w;
        logic [127:0] one, v;
        w = (sel == 2'd0) ? 7 : (sel == 2'd1) ? 10 : (sel == 2'd2) ? 16 : 18;
        one = 128'd1;
        v = 128'(imm) & ((one << w) - one);
        if (imm[w-1]) v = v - (one << w);
        return v;
    endfunction

    task automatic predict();
        logic el0, el1;
        el0 = rst_n && ev_req && (!m_vld[0] || ev_res_ack);
        el1 = rst_n && od_req && (!m_vld[1] || od_res_ack);
        e_gnt[0] = 1'b0;
        e_gnt[1] = 1'b0;
        if (el0 && el1) e_gnt[1 - m_last] = 1'b1;
        else if (el0) e_gnt[0] = 1'b1;
        else if (el1) e_gnt[1] = 1'b1;
    endtask

    task automatic advance();
        logic ack [2];
        ack[0] = ev_res_ack;
        ack[1] = od_res_ack;
        @(posedge clk);
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                m_vld[p] = 1'b0;
                m_res[p] = '0;
                m_tag[p] = '0;
            end
            m_last = 1;
        end else begin
            if (e_gnt[0]) begin
                m_res[0] = ref_ext(ev_sel, ev_imm);
                m_tag[0] = ev_tag;
            end
            if (e_gnt[1]) begin
                m_res[1] = ref_ext(od_sel, od_imm);
                m_tag[1] = od_tag;
            end
            for (int p = 0; p < 2; p++) begin
                if (e_gnt[p]) begin
                    m_vld[p] = 1'b1;
                    m_last = p;
                end else if (ack[p]) m_vld[p] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        ev_req = 0; od_req = 0; ev_res_ack = 0; od_res_ack = 0;
        ev_sel = 0; od_sel = 0; ev_imm = 0; od_imm = 0; ev_tag = 0; od_tag = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        predict();
        advance();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        ev_req = 1; od_req = 1;
        for (int i = 0; i < 2; i++) begin
            predict();
            #1;
            n_chk++;
            if (ev_gnt !== 1'b0 || od_gnt !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_gnt: ev_gnt=%b od_gnt=%b, required 0 0", ev_gnt, od_gnt);
            end
            advance();
        end
        n_chk++;
        if (ev_res_vld !== 1'b0 || od_res_vld !== 1'b0 || ev_res !== '0 || od_res !== '0 ||
            ev_res_tag !== '0 || od_res_tag !== '0) begin
            n_fail++;
            $display("FAIL reset_state: vld=%b/%b res=%h/%h tag=%h/%h, required all zero",
                     ev_res_vld, od_res_vld, ev_res, od_res, ev_res_tag, od_res_tag);
        end
        rst_n = 1'b1;
        idle_inputs();
    endtask

    task automatic test_single();
        do_reset();
        ev_req = 1; ev_sel = 2'b00; ev_imm = 18'h0005D; ev_tag = 7'd5;
        predict();
        #1;
        n_chk++;
        if (ev_gnt !== 1'b1 || od_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL single_gnt: ev_gnt=%b od_gnt=%b, required 1 0", ev_gnt, od_gnt);
        end
        advance();
        ev_req = 0;
        n_chk++;
        if (ev_res_vld !== 1'b1 || ev_res !== {{121{1'b1}}, 7'h5D} || ev_res_tag !== 7'd5) begin
            n_fail++;
            $display("FAIL single_res: vld=%b res=%h tag=%0d, required 1 %h 5",
                     ev_res_vld, ev_res, ev_res_tag, {{121{1'b1}}, 7'h5D});
        end
        ev_res_ack = 1;
        predict();
        advance();
        ev_res_ack = 0;
        n_chk++;
        if (ev_res_vld !== 1'b0 || ev_res !== m_res[0]) begin
            n_fail++;
            $display("FAIL single_ack: vld=%b res=%h, required 0 %h", ev_res_vld, ev_res, m_res[0]);
        end
    endtask

    task automatic test_contention();
        do_reset();
        ev_req = 1; ev_sel = 2'b11; ev_imm = 18'h001AD; ev_tag = 7'd1;
        od_req = 1; od_sel = 2'b01; od_imm = 18'h002AA; od_tag = 7'd2;
        predict();
        #1;
        n_chk++;
        if (ev_gnt !== 1'b1 || od_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL contend_c0: ev_gnt=%b od_gnt=%b, required 1 0", ev_gnt, od_gnt);
        end
        advance();
        ev_req = 0;
        predict();
        #1;
        n_chk++;
        if (ev_gnt !== 1'b0 || od_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL contend_c1: ev_gnt=%b od_gnt=%b, required 0 1", ev_gnt, od_gnt);
        end
        advance();
        od_req = 0;
        n_chk++;
        if (ev_res !== 128'h1AD || od_res !== {{118{1'b1}}, 10'h2AA} || ev_res_tag !== 7'd1 ||
            od_res_tag !== 7'd2 || ev_res_vld !== 1'b1 || od_res_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL contend_res: ev=%h od=%h tags=%0d/%0d vld=%b/%b, required %h %h 1/2 1/1",
                     ev_res, od_res, ev_res_tag, od_res_tag, ev_res_vld, od_res_vld,
                     128'h1AD, {{118{1'b1}}, 10'h2AA});
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ev_req = 1; ev_sel = 2'b00; ev_imm = 18'h1; ev_tag = 7'd3;
        predict();
        advance();
        ev_imm = 18'h2; ev_tag = 7'd4;
        od_req = 1; od_sel = 2'b10; od_imm = 18'h7FFF; od_tag = 7'd6; od_res_ack = 1;
        for (int i = 0; i < 3; i++) begin
            predict();
            #1;
            n_chk++;
            if (ev_gnt !== 1'b0 || od_gnt !== 1'b1) begin
                n_fail++;
                $display("FAIL backpressure_%0d: ev_gnt=%b od_gnt=%b, required 0 1", i, ev_gnt, od_gnt);
            end
            advance();
        end
        ev_res_ack = 1;
        predict();
        #1;
        n_chk++;
        if (ev_gnt !== 1'b1 || od_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_release: ev_gnt=%b od_gnt=%b, required 1 0", ev_gnt, od_gnt);
        end
        advance();
        idle_inputs();
        n_chk++;
        if (ev_res !== 128'h2 || ev_res_tag !== 7'd4 || od_res !== 128'h7FFF) begin
            n_fail++;
            $display("FAIL backpressure_res: ev=%h tag=%0d od=%h, required 2 4 7fff", ev_res, ev_res_tag, od_res);
        end
    endtask

    task automatic test_ack_grant();
        do_reset();
        ev_req = 1; ev_sel = 2'b00; ev_imm = 18'h0; ev_tag = 7'd1;
        predict();
        advance();
        ev_sel = 2'b10; ev_imm = 18'h08001; ev_tag = 7'd9; ev_res_ack = 1;
        predict();
        #1;
        n_chk++;
        if (ev_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL ackgnt_gnt: ev_gnt=%b, required 1", ev_gnt);
        end
        advance();
        idle_inputs();
        n_chk++;
        if (ev_res_vld !== 1'b1 || ev_res !== {{112{1'b1}}, 16'h8001} || ev_res_tag !== 7'd9) begin
            n_fail++;
            $display("FAIL ackgnt_res: vld=%b res=%h tag=%0d, required 1 %h 9",
                     ev_res_vld, ev_res, ev_res_tag, {{112{1'b1}}, 16'h8001});
        end
    endtask

    task automatic test_alternate();
        int got [2];
        got[0] = 0;
        got[1] = 0;
        do_reset();
        ev_req = 1; ev_sel = 2'b01; ev_imm = 18'h3FF; ev_tag = 7'd10; ev_res_ack = 1;
        od_req = 1; od_sel = 2'b11; od_imm = 18'h20000; od_tag = 7'd11; od_res_ack = 1;
        for (int i = 0; i < 8; i++) begin
            predict();
            #1;
            n_chk++;
            if (ev_gnt !== (i % 2 == 0) || od_gnt !== (i % 2 == 1)) begin
                n_fail++;
                $display("FAIL alternate_%0d: ev_gnt=%b od_gnt=%b, required %b %b",
                         i, ev_gnt, od_gnt, i % 2 == 0, i % 2 == 1);
            end
            if (ev_gnt) got[0]++;
            if (od_gnt) got[1]++;
            advance();
        end
        idle_inputs();
        n_chk++;
        if (got[0] != 4 || got[1] != 4) begin
            n_fail++;
            $display("FAIL alternate_count: ev=%0d od=%0d, required 4 4", got[0], got[1]);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        ev_req = 1; ev_sel = 2'b00; ev_imm = 18'h7F; ev_tag = 7'd7;
        od_req = 1; od_sel = 2'b00; od_imm = 18'h3F; od_tag = 7'd8;
        for (int i = 0; i < 2; i++) begin
            predict();
            advance();
        end
        rst_n = 1'b0;
        predict();
        #1;
        n_chk++;
        if (ev_gnt !== 1'b0 || od_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_gnt: ev_gnt=%b od_gnt=%b, required 0 0", ev_gnt, od_gnt);
        end
        advance();
        n_chk++;
        if (ev_res_vld !== 1'b0 || od_res_vld !== 1'b0 || ev_res !== '0 || od_res !== '0) begin
            n_fail++;
            $display("FAIL midreset_state: vld=%b/%b res=%h/%h, required 0 0 0 0",
                     ev_res_vld, od_res_vld, ev_res, od_res);
        end
        rst_n = 1'b1;
        predict();
        #1;
        n_chk++;
        if (ev_gnt !== 1'b1 || od_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_first: ev_gnt=%b od_gnt=%b, required 1 0", ev_gnt, od_gnt);
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_random();
        logic hold [2];
        do_reset();
        hold[0] = 1'b0;
        hold[1] = 1'b0;
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            if (!hold[0]) begin
                ev_req = $urandom_range(0, 3) != 0;
                ev_sel = 2'($urandom);
                ev_imm = 18'($urandom);
                ev_tag = 7'($urandom);
            end
            if (!hold[1]) begin
                od_req = $urandom_range(0, 3) != 0;
                od_sel = 2'($urandom);
                od_imm = 18'($urandom);
                od_tag = 7'($urandom);
            end
            ev_res_ack = $urandom_range(0, 2) == 0;
            od_res_ack = $urandom_range(0, 2) == 0;
            predict();
            #1;
            n_chk++;
            if (ev_gnt !== e_gnt[0] || od_gnt !== e_gnt[1]) begin
                n_fail++;
                $display("FAIL random_gnt_%0d: ev_gnt=%b od_gnt=%b, required %b %b",
                         i, ev_gnt, od_gnt, e_gnt[0], e_gnt[1]);
            end
            hold[0] = ev_req && !e_gnt[0];
            hold[1] = od_req && !e_gnt[1];
            advance();
            n_chk++;
            if (ev_res_vld !== m_vld[0] || ev_res !== m_res[0] || ev_res_tag !== m_tag[0] ||
                od_res_vld !== m_vld[1] || od_res !== m_res[1] || od_res_tag !== m_tag[1]) begin
                n_fail++;
                $display("FAIL random_slot_%0d: ev %b %h %h od %b %h %h, required ev %b %h %h od %b %h %h", i,
                         ev_res_vld, ev_res, ev_res_tag, od_res_vld, od_res, od_res_tag,
                         m_vld[0], m_res[0], m_tag[0], m_vld[1], m_res[1], m_tag[1]);
            end
        end
        rst_n = 1'b1;
        idle_inputs();
    endtask

    initial begin
        m_last = 1;
        for (int p = 0; p < 2; p++) begin
            m_vld[p] = 1'b0;
            m_res[p] = '0;
            m_tag[p] = '0;
        end
        idle_inputs();
        rst_n = 1'b0;
        #2;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_ack_grant();
        test_alternate();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
